branch_resolver: RTL and testbench

- EX-stage consumer of the ALU status flags (Z, N, C, V) produced by the compare operation (Op 4'b0011, A-B).
- Resolves RISC-V conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU), JAL and JALR.
- Registers the redirect target and drives the PC-select pulse to IF.
- Holds a multi-cycle flush of the younger IF/ID instructions through a small state machine.

---
 rtl/branch_resolver_pkg.sv | 21 ++
 rtl/branch_cond_eval.sv | 36 +++
 rtl/branch_resolver.sv | 145 ++++++++++++++
 tb/tb_branch_resolver.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the EX-stage branch resolver: funct3 branch encodings,
// ALU op codes used by decoder/ALU/resolver, and the resolver state type.
package branch_resolver_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Compare (A-B) produces the flags; op 4 produces the JALR target.
  localparam logic [3:0] ALU_OP_CMP  = 4'b0011;
  localparam logic [3:0] ALU_OP_JALR = 4'b0100;

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Pure combinational branch condition evaluation from funct3 and the A-B flags.
// Jumps are always taken; reserved funct3 values on a branch flag illegal.
module branch_cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       jal_i,
  input  logic       jalr_i,
  input  logic       z_i,
  input  logic       n_i,
  input  logic       c_i,
  input  logic       v_i,
  output logic       taken_o,
  output logic       illegal_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    if (jal_i || jalr_i) begin
      taken_o = 1'b1;
    end else begin
      case (funct3_i)
        BR_BEQ:  taken_o = z_i;
        BR_BNE:  taken_o = ~z_i;
        BR_BLT:  taken_o = n_i ^ v_i;
        BR_BGE:  taken_o = ~(n_i ^ v_i);
        BR_BLTU: taken_o = c_i;
        BR_BGEU: taken_o = ~c_i;
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch/jump resolver: registered redirect, PC-select pulse and a
// multi-cycle IF/ID flush. Define BR_STATS_EN to add branch outcome counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic [2:0]      funct3_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  input  logic            z_i,
  input  logic            n_i,
  input  logic            c_i,
  input  logic            v_i,
  input  logic [XLEN-1:0] target_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic            flush_o,
  output logic            busy_o,
  output logic            misalign_o,
`ifdef BR_STATS_EN
  output logic [31:0]     taken_cnt_o,
  output logic [31:0]     nottaken_cnt_o,
`endif
  output logic            illegal_o
);

  localparam int unsigned CNT_W = 3;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic              taken_q, taken_d;
  logic              mis_q, mis_d;
  logic              ill_q, ill_d;
  logic              cond_taken, cond_illegal, accept;

  branch_cond_eval u_cond (
    .funct3_i  (funct3_i),
    .jal_i     (jal_i),
    .jalr_i    (jalr_i),
    .z_i       (z_i),
    .n_i       (n_i),
    .c_i       (c_i),
    .v_i       (v_i),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  assign accept = (state_q == S_IDLE) && valid_i && !stall_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    taken_d  = 1'b0;
    mis_d    = 1'b0;
    ill_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cond_taken) begin
            if (target_i[1]) begin
              mis_d = 1'b1;
            end else begin
              taken_d  = 1'b1;
              target_d = target_i & ~XLEN'(1);
              state_d  = S_FLUSH;
              cnt_d    = CNT_W'(FLUSH_CYCLES);
            end
          end else if (cond_illegal) begin
            ill_d = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // valid_i is ignored here: that instruction is being squashed.
        if (!stall_i) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      taken_q  <= taken_d;
      mis_q    <= mis_d;
      ill_q    <= ill_d;
    end
  end

  assign taken_o    = taken_q;
  assign target_o   = target_q;
  assign misalign_o = mis_q;
  assign illegal_o  = ill_q;
  assign flush_o    = (state_q == S_FLUSH);
  assign busy_o     = (state_q == S_FLUSH);

`ifdef BR_STATS_EN
  logic [31:0] tk_cnt_q, nt_cnt_q;
  logic        is_cond;

  // Only legal conditional branches count; misaligned taken ones do not.
  assign is_cond = accept && !jal_i && !jalr_i && !cond_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tk_cnt_q <= '0;
      nt_cnt_q <= '0;
    end else if (is_cond) begin
      if (cond_taken && !target_i[1] && (tk_cnt_q != 32'hFFFF_FFFF))
        tk_cnt_q <= tk_cnt_q + 32'd1;
      if (!cond_taken && (nt_cnt_q != 32'hFFFF_FFFF))
        nt_cnt_q <= nt_cnt_q + 32'd1;
    end
  end

  assign taken_cnt_o    = tk_cnt_q;
  assign nottaken_cnt_o = nt_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: table-driven vectors through a
// scoreboard queue, plus hand-written stall, back-to-back and reset sequences.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, stall_i, jal_i, jalr_i, z_i, n_i, c_i, v_i;
  logic [2:0]  funct3_i;
  logic [31:0] target_i;
  logic        taken_o, flush_o, busy_o, misalign_o, illegal_o;
  logic [31:0] target_o;
`ifdef BR_STATS_EN
  logic [31:0] taken_cnt_o, nottaken_cnt_o;
`endif

  branch_resolver #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .stall_i    (stall_i),
    .funct3_i   (funct3_i),
    .jal_i      (jal_i),
    .jalr_i     (jalr_i),
    .z_i        (z_i),
    .n_i        (n_i),
    .c_i        (c_i),
    .v_i        (v_i),
    .target_i   (target_i),
    .taken_o    (taken_o),
    .target_o   (target_o),
    .flush_o    (flush_o),
    .busy_o     (busy_o),
    .misalign_o (misalign_o),
`ifdef BR_STATS_EN
    .taken_cnt_o    (taken_cnt_o),
    .nottaken_cnt_o (nottaken_cnt_o),
`endif
    .illegal_o  (illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jal, jalr;
    logic [2:0]  f3;
    logic        z, n, c, v;
    logic [31:0] tgt;
    logic        e_taken, e_mis, e_ill;
    logic [31:0] e_tgt;
  } vec_t;

  typedef struct {
    logic        taken, mis, ill;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb_q[$];
  vec_t vt[16];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    exp_t e;
    jal_i = t.jal; jalr_i = t.jalr; funct3_i = t.f3;
    z_i = t.z; n_i = t.n; c_i = t.c; v_i = t.v;
    target_i = t.tgt; valid_i = 1'b1;
    e.taken = t.e_taken; e.mis = t.e_mis; e.ill = t.e_ill; e.tgt = t.e_tgt;
    sb_q.push_back(e);
  endtask

  // Pop the scoreboard and compare the registered result one cycle after acceptance.
  task automatic compare(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb_q.pop_front();
    check({nm, ".taken"}, 32'(taken_o), 32'(e.taken));
    check({nm, ".misalign"}, 32'(misalign_o), 32'(e.mis));
    check({nm, ".illegal"}, 32'(illegal_o), 32'(e.ill));
    check({nm, ".target"}, target_o, e.tgt);
    check({nm, ".flush"}, 32'(flush_o), 32'(e.taken));
  endtask

  // Apply one vector at a negedge and follow the whole flush profile back to IDLE.
  task automatic apply(input vec_t t, input string nm);
    logic exp_tk;
    exp_tk = t.e_taken;
    drive(t);
    @(negedge clk);
    valid_i = 1'b0;
    compare(nm);
    @(negedge clk);
    check({nm, ".pulse_end"}, 32'({taken_o, misalign_o, illegal_o}), 32'd0);
    check({nm, ".flush2"}, 32'(flush_o), 32'(exp_tk));
    @(negedge clk);
    check({nm, ".idle"}, 32'({flush_o, busy_o}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    int   fl_cnt;
    //           jal jalr f3       z  n  c  v  tgt            tk mis ill exp_tgt
    vt[0]  = '{1'b0, 1'b0, BR_BLT,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0100};
    vt[1]  = '{1'b0, 1'b0, BR_BLTU, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 32'h0000_0040};
    vt[2]  = '{1'b0, 1'b0, BR_BGEU, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 32'h0000_0040};
    vt[3]  = '{1'b0, 1'b1, 3'b000,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0203, 1'b0, 1'b1, 1'b0, 32'h0000_0040};
    vt[4]  = '{1'b0, 1'b1, 3'b000,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0205, 1'b1, 1'b0, 1'b0, 32'h0000_0204};
    vt[5]  = '{1'b0, 1'b0, 3'b010,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b1, 32'h0000_0204};
    vt[6]  = '{1'b1, 1'b0, 3'b011,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 32'h0000_0300};
    vt[7]  = '{1'b0, 1'b0, BR_BEQ,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 32'h0000_0300};
    vt[8]  = '{1'b0, 1'b0, BR_BNE,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'h0000_0010};
    vt[9]  = '{1'b0, 1'b0, BR_BGE,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 32'h0000_0020};
    vt[10] = '{1'b0, 1'b0, BR_BLT,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 32'h0000_0020};
    vt[11] = '{1'b0, 1'b0, BR_BEQ,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 32'h0000_0020};
    vt[12] = '{1'b1, 1'b1, 3'b000,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'h0000_1000};
    vt[13] = '{1'b0, 1'b0, BR_BLT,  1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC};
    vt[14] = '{1'b0, 1'b0, BR_BGE,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC};
    vt[15] = '{1'b0, 1'b0, 3'b011,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC};

    rst_n = 1'b0; valid_i = 1'b0; stall_i = 1'b0; jal_i = 1'b0; jalr_i = 1'b0;
    funct3_i = '0; z_i = 1'b0; n_i = 1'b0; c_i = 1'b0; v_i = 1'b0; target_i = '0;
    repeat (2) @(negedge clk);
    check("reset.outputs", 32'({taken_o, flush_o, busy_o, misalign_o, illegal_o}), 32'd0);
    check("reset.target", target_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) apply(vt[i], $sformatf("vec%0d", i));

    // Taken BEQ, then 3 stalled cycles inside FLUSH with a would-be-taken BNE presented.
    t = '{1'b0, 1'b0, BR_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0050, 1'b1, 1'b0, 1'b0, 32'h0000_0050};
    drive(t);
    @(negedge clk);
    compare("stall.accept");
    fl_cnt = flush_o ? 1 : 0;
    stall_i = 1'b1; funct3_i = BR_BNE; z_i = 1'b0; target_i = 32'h0000_0090; valid_i = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      if (flush_o) fl_cnt++;
      check($sformatf("stall.no_pulse%0d", k), 32'({taken_o, misalign_o, illegal_o}), 32'd0);
      if (k == 4) stall_i = 1'b0;
      if (k == 5) valid_i = 1'b0;
    end
    check("stall.flush_cycles", 32'(fl_cnt), 32'd5);
    check("stall.target_held", target_o, 32'h0000_0050);

    // Stall in IDLE blocks acceptance.
    valid_i = 1'b1; stall_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    check("idle_stall.no_accept", 32'({taken_o, flush_o, busy_o}), 32'd0);
    check("idle_stall.target", target_o, 32'h0000_0050);

    // Reset pulse mid-FLUSH aborts at once; next taken BNE flushes normally.
    t = '{1'b0, 1'b0, BR_BLT, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0100};
    drive(t);
    @(negedge clk);
    valid_i = 1'b0;
    compare("rst.accept");
    #1 rst_n = 1'b0;
    #1;
    check("rst.async_outputs", 32'({taken_o, flush_o, busy_o, misalign_o, illegal_o}), 32'd0);
    check("rst.async_target", target_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.not_resumed", 32'({flush_o, busy_o}), 32'd0);
    t = '{1'b0, 1'b0, BR_BNE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0070, 1'b1, 1'b0, 1'b0, 32'h0000_0070};
    apply(t, "rst.bne");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
